// File: rtl/ttl_nor_array_reg.sv
// Registered CHANNELS x INPUTS gate bank (NOR/OR/NAND/AND) with a clock-enabled output
// pipeline, fill tracking and per-channel saturating toggle counters. Optional macro: TTL_NOR_ARRAY_TIMING_EN.
module ttl_nor_array_reg #(
    parameter int unsigned  CHANNELS = 4,
    parameter int unsigned  INPUTS   = 2,
    parameter int unsigned  STAGES   = 1,
    parameter int unsigned  CNT_W    = 8,
    localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                         CLK,
    input  logic                         CLR_N,
    input  logic                         EN,
    input  logic [1:0]                   MODE,
    input  logic [CHANNELS*INPUTS-1:0]   A,
    output logic [CHANNELS-1:0]          Y_COMB,
    output logic [CHANNELS-1:0]          Y,
    output logic                         VALID,
    input  logic                         CNT_CLR,
    input  logic [SEL_W-1:0]             CNT_SEL,
    output logic [CNT_W-1:0]             CNT
);

    localparam int unsigned       FILL_W  = $clog2(STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = '1;

    typedef enum logic [1:0] {
        MODE_NOR  = 2'b00,
        MODE_OR   = 2'b01,
        MODE_NAND = 2'b10,
        MODE_AND  = 2'b11
    } mode_e;

    generate
        if (CHANNELS < 1 || CHANNELS > 16 || INPUTS < 2 || INPUTS > 8 ||
            STAGES < 1 || STAGES > 8 || CNT_W < 1 || CNT_W > 16) begin : g_param_err
            $error("ttl_nor_array_reg: parameter out of range");
        end
    endgenerate

    logic [CHANNELS-1:0]                  y_comb_c;
    logic [INPUTS-1:0]                    chan_c;
    logic [STAGES-1:0][CHANNELS-1:0]      stage_q, stage_d;
    logic [FILL_W-1:0]                    fill_q, fill_d;
    logic                                 valid_q, valid_d;
    logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]                     cnt_c;

    // Per-channel gate function selected by MODE
    always_comb begin
        y_comb_c = '0;
        chan_c   = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            chan_c = A[c*INPUTS +: INPUTS];
            case (mode_e'(MODE))
                MODE_NOR:  y_comb_c[c] = ~(|chan_c);
                MODE_OR:   y_comb_c[c] = |chan_c;
                MODE_NAND: y_comb_c[c] = ~(&chan_c);
                MODE_AND:  y_comb_c[c] = &chan_c;
                default:   y_comb_c[c] = 1'b0;
            endcase
        end
    end

    // Pipeline shift, fill tracking and toggle counting on enabled edges
    always_comb begin
        stage_d = stage_q;
        fill_d  = fill_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        if (EN) begin
            stage_d[0] = y_comb_c;
            for (int unsigned k = 1; k < STAGES; k++) begin
                stage_d[k] = stage_q[k-1];
            end
            if (fill_q != FILL_W'(STAGES)) begin
                fill_d = fill_q + FILL_W'(1);
            end
            valid_d = (fill_d == FILL_W'(STAGES));
            // Only post-fill transitions of the final stage are activity
            if (valid_q) begin
                for (int unsigned c = 0; c < CHANNELS; c++) begin
                    if ((stage_d[STAGES-1][c] != stage_q[STAGES-1][c]) && (cnt_q[c] != CNT_MAX)) begin
                        cnt_d[c] = cnt_q[c] + CNT_W'(1);
                    end
                end
            end
        end
        if (CNT_CLR) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            stage_q <= '0;
            fill_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            stage_q <= stage_d;
            fill_q  <= fill_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter read mux; selects beyond the last channel read as zero
    always_comb begin
        cnt_c = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            if (CNT_SEL == SEL_W'(c)) begin
                cnt_c = cnt_q[c];
            end
        end
    end

    assign CNT = cnt_c;

`ifdef TTL_NOR_ARRAY_TIMING_EN
    assign #(0:10:15, 0:10:15) Y_COMB = y_comb_c;
    assign #(0:8:12)           Y      = stage_q[STAGES-1];
    assign #(0:8:12)           VALID  = valid_q;
`else
    assign Y_COMB = y_comb_c;
    assign Y      = stage_q[STAGES-1];
    assign VALID  = valid_q;
`endif

endmodule

// File: tb/tb_ttl_nor_array_reg.sv
// Self-checking bench for ttl_nor_array_reg: directed pins plus randomized run against an
// edge-history model, on a 4ch/2in/2stage/2bit instance and a 3ch/3in/1stage/3bit instance.
module tb_ttl_nor_array_reg;

    localparam int P_CH [2] = '{4, 3};
    localparam int P_IN [2] = '{2, 3};
    localparam int P_ST [2] = '{2, 1};
    localparam int P_CW [2] = '{2, 3};
    localparam int HIST = 4096;

    logic       CLK;
    logic       CLR_N;
    logic       EN;
    logic [1:0] MODE;
    logic       CNT_CLR;
    logic [7:0] A;
    logic [1:0] CNT_SEL;
    logic [3:0] Y_COMB, Y;
    logic       VALID;
    logic [1:0] CNT;
    logic [8:0] A_b;
    logic [1:0] CNT_SEL_b;
    logic [2:0] Y_COMB_b, Y_b;
    logic       VALID_b;
    logic [2:0] CNT_b;

    int checks   = 0;
    int failures = 0;

    int          m_edges [2];
    logic [15:0] m_hist  [2][HIST];
    int          m_cnt   [2][16];

    ttl_nor_array_reg #(.CHANNELS(4), .INPUTS(2), .STAGES(2), .CNT_W(2)) u_dut (
        .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .MODE(MODE), .A(A),
        .Y_COMB(Y_COMB), .Y(Y), .VALID(VALID),
        .CNT_CLR(CNT_CLR), .CNT_SEL(CNT_SEL), .CNT(CNT)
    );

    ttl_nor_array_reg #(.CHANNELS(3), .INPUTS(3), .STAGES(1), .CNT_W(3)) u_dut_b (
        .CLK(CLK), .CLR_N(CLR_N), .EN(EN), .MODE(MODE), .A(A_b),
        .Y_COMB(Y_COMB_b), .Y(Y_b), .VALID(VALID_b),
        .CNT_CLR(CNT_CLR), .CNT_SEL(CNT_SEL_b), .CNT(CNT_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Gate result for every channel from the plain truth rules of each mode
    function automatic logic [15:0] gate_vec(input logic [31:0] a, input int ch, input int in,
                                             input logic [1:0] m);
        logic [15:0] r;
        int mask;
        int bits;
        r = '0;
        mask = (1 << in) - 1;
        for (int c = 0; c < ch; c++) begin
            bits = int'(a >> (c * in)) & mask;
            case (m)
                2'b00:   r[c] = (bits == 0);
                2'b01:   r[c] = (bits != 0);
                2'b10:   r[c] = (bits != mask);
                default: r[c] = (bits == mask);
            endcase
        end
        return r;
    endfunction

    // Y is the gate result captured STAGES enabled edges ago, zero until that many edges exist
    function automatic logic [15:0] m_y(input int i);
        if (m_edges[i] >= P_ST[i]) return m_hist[i][m_edges[i] - P_ST[i]];
        return 16'h0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_edges[i] = 0;
            for (int c = 0; c < 16; c++) m_cnt[i][c] = 0;
        end
    endtask

    task automatic model_edge(input int i, input logic [31:0] a);
        logic [15:0] g, y_old, y_new;
        bit vb;
        g = gate_vec(a, P_CH[i], P_IN[i], MODE);
        if (EN && m_edges[i] < HIST) begin
            y_old = m_y(i);
            vb = (m_edges[i] >= P_ST[i]);
            m_hist[i][m_edges[i]] = g;
            m_edges[i]++;
            y_new = m_y(i);
            if (vb) begin
                for (int c = 0; c < P_CH[i]; c++) begin
                    if (y_old[c] != y_new[c] && m_cnt[i][c] < (1 << P_CW[i]) - 1) m_cnt[i][c]++;
                end
            end
        end
        if (CNT_CLR) begin
            for (int c = 0; c < 16; c++) m_cnt[i][c] = 0;
        end
    endtask

    always @(negedge CLR_N) model_reset();

    always @(posedge CLK) begin
        if (CLR_N) begin
            model_edge(0, 32'(A));
            model_edge(1, 32'(A_b));
        end
    end

    task automatic compare_all();
        logic [15:0] e;
        int s;
        e = gate_vec(32'(A), 4, 2, MODE);
        chk("y_comb", 32'(Y_COMB), 32'(e[3:0]));
        e = m_y(0);
        chk("y", 32'(Y), 32'(e[3:0]));
        chk("valid", 32'(VALID), 32'(m_edges[0] >= 2));
        s = int'(CNT_SEL);
        chk("cnt", 32'(CNT), 32'(m_cnt[0][s]));
        e = gate_vec(32'(A_b), 3, 3, MODE);
        chk("y_comb_b", 32'(Y_COMB_b), 32'(e[2:0]));
        e = m_y(1);
        chk("y_b", 32'(Y_b), 32'(e[2:0]));
        chk("valid_b", 32'(VALID_b), 32'(m_edges[1] >= 1));
        s = int'(CNT_SEL_b);
        chk("cnt_b", 32'(CNT_b), (s < 3) ? 32'(m_cnt[1][s]) : 32'h0);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #4;
            compare_all();
        end
    end

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    initial begin
        logic [3:0] mode_exp [4];
        mode_exp = '{4'h6, 4'h9, 4'h6, 4'h9};
        model_reset();
        CLR_N = 1'b0; EN = 1'b0; MODE = 2'b00; A = 8'h00; A_b = 9'h000;
        CNT_CLR = 1'b0; CNT_SEL = 2'd1; CNT_SEL_b = 2'd3;
        #1;
        chk("rst_y_comb", 32'(Y_COMB), 32'hF);
        chk("rst_y", 32'(Y), 32'h0);
        chk("rst_valid", 32'(VALID), 32'h0);
        chk("rst_cnt", 32'(CNT), 32'h0);
        A = 8'h01;
        #1;
        chk("rst_y_comb_live", 32'(Y_COMB), 32'hE);
        tick();
        tick();

        // Fill and latency
        A = 8'h55; EN = 1'b1;
        #1 CLR_N = 1'b1;
        tick(); chk("fill1_y", 32'(Y), 32'h0); chk("fill1_valid", 32'(VALID), 32'h0);
        tick(); chk("fill2_y", 32'(Y), 32'h0); chk("fill2_valid", 32'(VALID), 32'h1);
        A = 8'h00;
        tick(); chk("lat1_y", 32'(Y), 32'h0);
        tick(); chk("lat2_y", 32'(Y), 32'hF);

        // Modes
        A = 8'hC3;
        for (int m = 0; m < 4; m++) begin
            MODE = 2'(m);
            tick();
            chk("mode_y_comb", 32'(Y_COMB), 32'(mode_exp[m]));
        end
        MODE = 2'b00; A = 8'h00; CNT_CLR = 1'b1;
        tick(); tick();
        CNT_CLR = 1'b0;
        chk("settle_y", 32'(Y), 32'hF);
        chk("settle_cnt", 32'(CNT), 32'h0);

        // Hold
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            A = 8'($urandom); MODE = 2'($urandom);
            tick();
            chk("hold_y", 32'(Y), 32'hF);
            chk("hold_valid", 32'(VALID), 32'h1);
            chk("hold_cnt", 32'(CNT), 32'h0);
        end
        MODE = 2'b00; EN = 1'b1; A = 8'hFF;
        tick(); chk("resume1_y", 32'(Y), 32'hF);
        tick(); chk("resume2_y", 32'(Y), 32'h0);
        A = 8'h00;
        tick(); tick();
        chk("resume_back_y", 32'(Y), 32'hF);
        chk("resume_cnt", 32'(CNT), 32'h2);
        CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
        chk("clr_cnt", 32'(CNT), 32'h0);

        // Saturation: five toggles of channel 1 on a 2-bit counter
        for (int i = 0; i < 7; i++) begin
            A = (i % 2 == 0 || i >= 4) ? 8'h0C : 8'h00;
            tick();
        end
        chk("sat_cnt", 32'(CNT), 32'h3);
        CNT_SEL = 2'd0; #1;
        chk("other_ch_cnt", 32'(CNT), 32'h0);
        CNT_SEL = 2'd1;
        A = 8'h00; tick();
        CNT_CLR = 1'b1; tick(); CNT_CLR = 1'b0;
        chk("clr_wins_cnt", 32'(CNT), 32'h0);

        // Mid-operation asynchronous reset
        A = 8'h0C; tick(); tick();
        A = 8'h00; tick(); tick();
        chk("pre_rst_cnt", 32'(CNT), 32'h2);
        chk("pre_rst_valid", 32'(VALID), 32'h1);
        #3 CLR_N = 1'b0;
        #1;
        chk("async_y", 32'(Y), 32'h0);
        chk("async_valid", 32'(VALID), 32'h0);
        chk("async_cnt", 32'(CNT), 32'h0);
        #2 CLR_N = 1'b1;
        tick(); chk("refill1_valid", 32'(VALID), 32'h0);
        tick(); chk("refill2_valid", 32'(VALID), 32'h1); chk("refill2_y", 32'(Y), 32'hF);

        // Randomized run
        for (int n = 0; n < 1200; n++) begin
            EN        = ($urandom_range(0, 3) != 0);
            MODE      = 2'($urandom);
            A         = 8'($urandom);
            A_b       = 9'($urandom);
            CNT_CLR   = ($urandom_range(0, 15) == 0);
            CNT_SEL   = 2'($urandom);
            CNT_SEL_b = 2'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #3 CLR_N = 1'b0;
                #2 CLR_N = 1'b1;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
